// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access unit: op encodings, FSM states, lane widths
// and the request decode helpers used at acceptance.
package mem_access_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned HalfW = 16;
  localparam int unsigned WordW = 32;

  typedef enum logic [2:0] {
    OpLb  = 3'd0,
    OpLbu = 3'd1,
    OpLh  = 3'd2,
    OpLhu = 3'd3,
    OpLw  = 3'd4,
    OpSb  = 3'd5,
    OpSh  = 3'd6,
    OpSw  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } state_e;

  function automatic logic is_store(mem_op_e op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] addr_lo);
    logic mis;
    case (op)
      OpLh, OpLhu, OpSh: mis = addr_lo[0];
      OpLw, OpSw:        mis = (addr_lo != 2'b00);
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends load data from a RAM word and
// merges byte/halfword store data into a RAM word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  mem_op_e            op,
  input  logic [1:0]         addr_lo,
  input  logic [WordW-1:0]   word,
  input  logic [WordW-1:0]   wdata,
  output logic [WordW-1:0]   load_data,
  output logic [WordW-1:0]   store_word
);

  logic [ByteW-1:0] byte_sel;
  logic [HalfW-1:0] half_sel;
  logic [4:0]       byte_pos;
  logic [4:0]       half_pos;

  assign byte_pos = {addr_lo, 3'b000};
  assign half_pos = {addr_lo[1], 4'b0000};

  always_comb begin
    byte_sel = word[byte_pos +: ByteW];
    half_sel = word[half_pos +: HalfW];

    load_data = '0;
    unique case (op)
      OpLb:    load_data = {{(WordW - ByteW){byte_sel[ByteW-1]}}, byte_sel};
      OpLbu:   load_data = {{(WordW - ByteW){1'b0}}, byte_sel};
      OpLh:    load_data = {{(WordW - HalfW){half_sel[HalfW-1]}}, half_sel};
      OpLhu:   load_data = {{(WordW - HalfW){1'b0}}, half_sel};
      OpLw:    load_data = word;
      default: load_data = '0;
    endcase

    // Only the addressed lane changes; the rest of the fetched word is kept.
    store_word = word;
    unique case (op)
      OpSb:    store_word[byte_pos +: ByteW] = wdata[ByteW-1:0];
      OpSh:    store_word[half_pos +: HalfW] = wdata[HalfW-1:0];
      OpSw:    store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: one request at a time, read-modify-write for sub-word
// stores, registered RAM address/data so the level-sensitive write stays stable.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_in,
  output logic        ram_read,
  output logic        ram_write,
  input  logic [31:0] ram_data_out
);

  localparam logic [31:0] LastAddr = 32'(MEM_BYTES - 1);

  state_e      state_q, state_d;
  mem_op_e     op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wr_word_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  mem_op_e     req_op_e;
  logic        req_err;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_op_e = mem_op_e'(req_op);
  // The full word containing the address must lie inside the RAM.
  assign req_err  = is_misaligned(req_op_e, req_addr[1:0]) ||
                    (({req_addr[31:2], 2'b00} + 32'd3) > LastAddr);
  assign accept   = req_valid && (state_q == StIdle);

  mem_lane_align u_lane_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .word       (ram_data_out),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err)               state_d = StResp;
          else if (req_op_e == OpSw) state_d = StWr;
          else                       state_d = StRd;
        end
      end
      StRd:    state_d = is_store(op_q) ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      op_q         <= OpLb;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_word_q    <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op_e;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_err) begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b1;
        end else if (req_op_e == OpSw) begin
          wr_word_q <= req_wdata;
        end
      end
      if (state_q == StRd) begin
        if (is_store(op_q)) begin
          wr_word_q <= store_word;
        end else begin
          resp_rdata_q <= load_data;
          resp_err_q   <= 1'b0;
        end
      end
      if (state_q == StWr) begin
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    req_ready   = (state_q == StIdle);
    resp_valid  = (state_q == StResp);
    resp_rdata  = resp_rdata_q;
    resp_err    = resp_err_q;
    ram_read    = (state_q == StRd);
    ram_write   = (state_q == StWr);
    ram_addr    = (ram_read || ram_write) ? {addr_q[31:2], 2'b00} : 32'h0;
    ram_data_in = ram_write ? wr_word_q : 32'h0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a reference memory model predicts each
// response, strobe counts and write word; a negedge monitor pops and compares.
module tb_mem_access_unit;

  localparam int unsigned MemBytes = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_in;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_data_out;

  mem_access_unit #(.MEM_BYTES(MemBytes)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_read     (ram_read),
    .ram_write    (ram_write),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:255];
  logic [31:0] ref_mem [0:255];

  assign ram_data_out = (ram_read && !ram_write) ? ram[ram_addr[9:2]] : 32'h0;
  always @(posedge clk) if (ram_write) ram[ram_addr[9:2]] <= ram_data_in;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic        chk_wr;
    logic [31:0] wword;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int overlap = 0;
  int idle_drive = 0;
  logic [31:0] wr_word = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: predicts the response and updates the reference memory.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t e;
    logic mis;
    logic [31:0] w, nw;
    int sh, hs;
    logic [7:0] b;
    logic [15:0] h;
    e = '{rdata: 32'h0, err: 1'b0, lat: 0, nrd: 0, nwr: 0, chk_wr: 1'b0, wword: 32'h0, acc: 0};
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) mis = addr[0];
    else if (op == 3'd4 || op == 3'd7)         mis = (addr[1:0] != 2'b00);
    else                                        mis = 1'b0;
    e.err = mis || (((addr & ~32'd3) + 32'd3) > (MemBytes - 1));
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    w  = ref_mem[addr[9:2]];
    sh = int'(addr[1:0]) * 8;
    hs = int'(addr[1]) * 16;
    b  = 8'(w >> sh);
    h  = 16'(w >> hs);
    nw = w;
    case (op)
      3'd0: e.rdata = {{24{b[7]}}, b};
      3'd1: e.rdata = {24'h0, b};
      3'd2: e.rdata = {{16{h[15]}}, h};
      3'd3: e.rdata = {16'h0, h};
      3'd4: e.rdata = w;
      3'd5: nw = (w & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
      3'd6: nw = (w & ~(32'hFFFF << hs)) | ({16'h0, wdata[15:0]} << hs);
      default: nw = wdata;
    endcase
    if (op >= 3'd5) begin
      ref_mem[addr[9:2]] = nw;
      e.wword  = nw;
      e.chk_wr = 1'b1;
      e.nwr    = 1;
      e.nrd    = (op == 3'd7) ? 0 : 1;
      e.lat    = (op == 3'd7) ? 2 : 3;
    end else begin
      e.nrd = 1;
      e.lat = 2;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ram_read && ram_write) overlap++;
    if (!ram_read && !ram_write && (ram_addr != 32'h0 || ram_data_in != 32'h0)) idle_drive++;
    if (ram_read) rd_cnt++;
    if (ram_write) begin
      wr_cnt++;
      wr_word = ram_data_in;
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("rdata", resp_rdata, e.rdata);
        check_eq("err", {31'h0, resp_err}, {31'h0, e.err});
        check_eq("latency", 32'(cyc - e.acc), 32'(e.lat));
        check_eq("read_cycles", 32'(rd_cnt), 32'(e.nrd));
        check_eq("write_cycles", 32'(wr_cnt), 32'(e.nwr));
        if (e.chk_wr) check_eq("write_word", wr_word, e.wword);
      end
      rd_cnt = 0;
      wr_cnt = 0;
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    check_eq("resp_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // poke: during the RD cycle of a load, present a conflicting store that must be ignored.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit poke);
    exp_t e;
    e = model(op, addr, wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    e.acc     = cyc;
    sb.push_back(e);
    @(negedge clk);
    if (poke) begin
      req_op    = 3'd7;
      req_addr  = addr & ~32'd3;
      req_wdata = 32'hDEADBEEF;
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4]     = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'h0, req_ready}, 32'd1);
    check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_err", {31'h0, resp_err}, 32'd0);
    check_eq("rst_strobes", {30'h0, ram_read, ram_write}, 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_ram_data_in", ram_data_in, 32'h0);
    reset = 1'b0;

    issue(3'd0, 32'h13, 32'h0, 1'b0);          // LB
    issue(3'd1, 32'h13, 32'h0, 1'b0);          // LBU
    issue(3'd2, 32'h12, 32'h0, 1'b0);          // LH
    issue(3'd3, 32'h12, 32'h0, 1'b0);          // LHU
    issue(3'd4, 32'h10, 32'h0, 1'b0);          // LW
    issue(3'd5, 32'h11, 32'h000000C3, 1'b0);   // SB merge
    issue(3'd4, 32'h10, 32'h0, 1'b0);
    check_eq("sb_merge_value", ram[4], 32'h8899C3BB);
    issue(3'd7, 32'h22, 32'h12345678, 1'b0);   // misaligned SW
    issue(3'd4, 32'h3E8, 32'h0, 1'b0);         // out of range
    issue(3'd6, 32'h11, 32'h0000BEEF, 1'b0);   // misaligned SH
    issue(3'd6, 32'h16, 32'h1234BEEF, 1'b0);
    issue(3'd3, 32'h16, 32'h0, 1'b0);
    issue(3'd7, 32'h20, 32'hCAFEF00D, 1'b0);
    issue(3'd0, 32'h21, 32'h0, 1'b0);
    issue(3'd4, 32'h3E4, 32'h0, 1'b0);         // last legal word
    issue(3'd0, 32'h3E7, 32'h0, 1'b0);
    issue(3'd0, 32'h3E8, 32'h0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      issue(3'($urandom_range(7)), 32'($urandom_range(1023)), $urandom, 1'b0);
    end

    // Conflicting request while busy is ignored; memory must be untouched.
    issue(3'd4, 32'h10, 32'h0, 1'b1);
    issue(3'd4, 32'h10, 32'h0, 1'b0);

    // Reset during RD aborts the load without a response.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_addr  = 32'h10;
    @(negedge clk);
    req_op    = 3'd7;
    req_wdata = 32'h0;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    check_eq("abort_ready", {31'h0, req_ready}, 32'd1);
    check_eq("abort_strobes", {30'h0, ram_read, ram_write}, 32'd0);
    check_eq("abort_rdata", resp_rdata, 32'h0);
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (3) @(negedge clk);
    check_eq("abort_ram_word", ram[4], ref_mem[4]);
    issue(3'd4, 32'h10, 32'h0, 1'b0);

    // A request presented with reset is dropped.
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_addr  = 32'h10;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    rd_cnt    = 0;
    repeat (4) @(negedge clk);
    check_eq("drop_ready", {31'h0, req_ready}, 32'd1);
    check_eq("drop_no_read", 32'(rd_cnt), 32'd0);

    check_eq("strobe_overlap", 32'(overlap), 32'd0);
    check_eq("idle_ram_drive", 32'(idle_drive), 32'd0);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
